motion_alarm: RTL and testbench

- Multi-channel successor to the single-sensor motion/buzzer block.
- Synchronises and debounces N motion sensors, then runs an arm/exit-delay/armed/alarm state machine.
- Outputs a pulsed buzzer pattern with an alarm hold time and records which sensors tripped.
- Sits between the PIR sensor pins and the buzzer/status LEDs of the security subsystem.

---
 rtl/motion_alarm.sv | 167 ++++++++++++++++
 tb/tb_motion_alarm.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/motion_alarm.sv
// motion_alarm: N-channel PIR synchroniser/debouncer feeding an arm/exit/armed/alarm FSM with a pulsed buzzer.
// Build option MOTION_ALARM_LATCH_EN: ALARM never times out; only ack or arm = 0 leave it.
module motion_alarm #(
  parameter int unsigned CLK_FREQ     = 50000000,
  parameter int unsigned N_SENSORS    = 4,
  parameter int unsigned DEBOUNCE_MS  = 20,
  parameter int unsigned ARM_DELAY_MS = 10000,
  parameter int unsigned HOLD_MS      = 5000,
  parameter int unsigned BEEP_HALF_MS = 250
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 arm,
  input  logic                 ack,
  input  logic [N_SENSORS-1:0] motion_sensor,
  output logic                 buzzer,
  output logic                 alarm_active,
  output logic                 armed,
  output logic [N_SENSORS-1:0] trip_mask,
  output logic [1:0]           state
);

  localparam int unsigned CYC_PER_MS = CLK_FREQ / 1000;
  localparam int unsigned DEB_CYC    = DEBOUNCE_MS * CYC_PER_MS;
  localparam int unsigned ARM_CYC    = ARM_DELAY_MS * CYC_PER_MS;
  localparam int unsigned BEEP_CYC   = BEEP_HALF_MS * CYC_PER_MS;

  localparam int unsigned DEB_W  = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int unsigned ARM_W  = (ARM_CYC > 1) ? $clog2(ARM_CYC) : 1;
  localparam int unsigned BEEP_W = (BEEP_CYC > 1) ? $clog2(BEEP_CYC) : 1;

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYC - 1);
  localparam logic [ARM_W-1:0]  ARM_LOAD  = ARM_W'(ARM_CYC - 1);
  localparam logic [BEEP_W-1:0] BEEP_LOAD = BEEP_W'(BEEP_CYC - 1);

`ifndef MOTION_ALARM_LATCH_EN
  localparam int unsigned HOLD_CYC  = HOLD_MS * CYC_PER_MS;
  localparam int unsigned HOLD_W    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYC - 1);
  logic [HOLD_W-1:0] hold_cnt;
`endif

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_EXIT     = 2'd1,
    ST_ARMED    = 2'd2,
    ST_ALARM    = 2'd3
  } state_t;

  state_t               st;
  state_t               nxt;
  logic [N_SENSORS-1:0] sync1;
  logic [N_SENSORS-1:0] sync2;
  logic [N_SENSORS-1:0] det;
  logic [DEB_W-1:0]     cnt [N_SENSORS];
  logic [ARM_W-1:0]     exit_cnt;
  logic [BEEP_W-1:0]    beep_cnt;
  logic                 any_det;

  assign any_det = |det;
  assign state   = st;

  // Two-flop synchroniser for the asynchronous sensor lines
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= motion_sensor;
      sync2 <= sync1;
    end
  end

  // Per-channel stable-high debounce; any low sample restarts the channel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      det <= '0;
      for (int i = 0; i < int'(N_SENSORS); i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < int'(N_SENSORS); i++) begin
        if (!sync2[i]) begin
          cnt[i] <= '0;
          det[i] <= 1'b0;
        end else if (cnt[i] == DEB_LAST) begin
          det[i] <= 1'b1;
        end else begin
          cnt[i] <= cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  // Next-state decode; disarm overrides everything, ack beats timeout and new detections
  always_comb begin
    nxt = st;
    if (!arm) begin
      nxt = ST_DISARMED;
    end else begin
      case (st)
        ST_DISARMED: nxt = ST_EXIT;
        ST_EXIT:     if (exit_cnt == '0) nxt = ST_ARMED;
        ST_ARMED:    if (any_det) nxt = ST_ALARM;
        ST_ALARM: begin
          if (ack) nxt = ST_ARMED;
`ifndef MOTION_ALARM_LATCH_EN
          else if (hold_cnt == '0 && !any_det) nxt = ST_ARMED;
`endif
        end
        default:     nxt = ST_DISARMED;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st           <= ST_DISARMED;
      buzzer       <= 1'b0;
      alarm_active <= 1'b0;
      armed        <= 1'b0;
      trip_mask    <= '0;
      exit_cnt     <= '0;
      beep_cnt     <= '0;
`ifndef MOTION_ALARM_LATCH_EN
      hold_cnt     <= '0;
`endif
    end else begin
      st           <= nxt;
      alarm_active <= (nxt == ST_ALARM);
      armed        <= (nxt == ST_ARMED) || (nxt == ST_ALARM);

      if (nxt == ST_EXIT && st != ST_EXIT) begin
        exit_cnt  <= ARM_LOAD;
        trip_mask <= '0;
      end else if (st == ST_EXIT && exit_cnt != '0) begin
        exit_cnt <= exit_cnt - ARM_W'(1);
      end

      if (nxt == ST_ALARM) begin
        if (st != ST_ALARM) begin
          trip_mask <= det;
          beep_cnt  <= BEEP_LOAD;
          buzzer    <= 1'b1;
`ifndef MOTION_ALARM_LATCH_EN
          hold_cnt  <= HOLD_LOAD;
`endif
        end else begin
          trip_mask <= trip_mask | det;
          if (beep_cnt == '0) begin
            buzzer   <= ~buzzer;
            beep_cnt <= BEEP_LOAD;
          end else begin
            beep_cnt <= beep_cnt - BEEP_W'(1);
          end
`ifndef MOTION_ALARM_LATCH_EN
          if (any_det) hold_cnt <= HOLD_LOAD;
          else if (hold_cnt != '0) hold_cnt <= hold_cnt - HOLD_W'(1);
`endif
        end
      end else begin
        buzzer <= 1'b0;
        // An acknowledged alarm starts a fresh trip record
        if (st == ST_ALARM && nxt == ST_ARMED && ack) trip_mask <= '0;
      end
    end
  end

endmodule

// File: tb/tb_motion_alarm.sv
// tb_motion_alarm: scoreboard bench for motion_alarm; expectations are queued with a due cycle when stimulus is driven.
// Build with MOTION_ALARM_LATCH_EN defined to exercise the non-timing-out alarm variant.
module tb_motion_alarm;

  localparam int F_STATE = 0;
  localparam int F_TRIP  = 1;
  localparam int F_BUZ   = 2;
  localparam int F_ACT   = 3;
  localparam int F_ARMED = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       arm;
  logic       ack;
  logic [3:0] motion;
  logic       buzzer;
  logic       alarm_active;
  logic       armed;
  logic [3:0] trip_mask;
  logic [1:0] state;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  int         q_due [$];
  int         q_fld [$];
  logic [7:0] q_exp [$];
  string      q_tag [$];

  motion_alarm #(
    .CLK_FREQ    (1000),
    .N_SENSORS   (4),
    .DEBOUNCE_MS (5),
    .ARM_DELAY_MS(10),
    .HOLD_MS     (50),
    .BEEP_HALF_MS(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .arm          (arm),
    .ack          (ack),
    .motion_sensor(motion),
    .buzzer       (buzzer),
    .alarm_active (alarm_active),
    .armed        (armed),
    .trip_mask    (trip_mask),
    .state        (state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [7:0] obs(input int fld);
    case (fld)
      F_STATE: return 8'(state);
      F_TRIP:  return 8'(trip_mask);
      F_BUZ:   return 8'(buzzer);
      F_ACT:   return 8'(alarm_active);
      default: return 8'(armed);
    endcase
  endfunction

  // Queue an expectation for the sample point dt edges from now
  task automatic exp_at(input int dt, input int fld, input logic [7:0] v, input string tag);
    q_due.push_back(cyc + dt);
    q_fld.push_back(fld);
    q_exp.push_back(v);
    q_tag.push_back(tag);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare every expectation that falls due on this cycle
  always @(negedge clk) begin
    int k;
    k = 0;
    while (k < q_due.size()) begin
      if (q_due[k] == cyc) begin
        check_eq(q_tag[k], obs(q_fld[k]), q_exp[k]);
        q_due.delete(k);
        q_fld.delete(k);
        q_exp.delete(k);
        q_tag.delete(k);
      end else begin
        k++;
      end
    end
  end

  initial begin
    reset  = 1'b1;
    arm    = 1'b0;
    ack    = 1'b0;
    motion = 4'b0000;
    step(3);
    reset = 1'b0;
    exp_at(1, F_STATE, 8'd0, "init_state");
    exp_at(1, F_ARMED, 8'd0, "init_armed");
    exp_at(1, F_BUZ,   8'd0, "init_buzzer");
    exp_at(1, F_TRIP,  8'd0, "init_trip");
    exp_at(1, F_ACT,   8'd0, "init_active");
    step(2);

    // Arm: ten cycles of exit delay; a debounced pulse on sensor 2 during it is ignored
    arm = 1'b1;
    for (int k = 1; k <= 10; k++) exp_at(k, F_STATE, 8'd1, "exit_state");
    exp_at(10, F_ARMED, 8'd0, "exit_armed");
    exp_at(11, F_STATE, 8'd2, "armed_state");
    exp_at(11, F_ARMED, 8'd1, "armed_flag");
    step(1);
    motion[2] = 1'b1;
    step(7);
    motion[2] = 1'b0;
    exp_at(4, F_STATE, 8'd2, "exit_pulse_state");
    exp_at(4, F_ACT,   8'd0, "exit_pulse_active");
    step(5);

    // Short glitch on sensor 1 never debounces
    motion[1] = 1'b1;
    step(4);
    motion[1] = 1'b0;
    exp_at(6, F_STATE, 8'd2, "glitch_state");
    exp_at(6, F_ACT,   8'd0, "glitch_active");
    step(6);

    // Sensor 1 held: alarm 8 edges later, buzzer 4 high / 4 low
    motion[1] = 1'b1;
    exp_at(7, F_ACT,   8'd0, "pre_alarm_active");
    exp_at(8, F_STATE, 8'd3, "alarm_state");
    exp_at(8, F_ACT,   8'd1, "alarm_active");
    exp_at(8, F_ARMED, 8'd1, "alarm_armed");
    exp_at(8, F_TRIP,  8'h2, "alarm_trip");
    for (int k = 8; k < 24; k++)
      exp_at(k, F_BUZ, (((k - 8) / 4) % 2 == 0) ? 8'd1 : 8'd0, "beep_pattern");
    step(24);
    motion[1] = 1'b0;
    step(20);

    // Sensor 3 extends the alarm and joins the trip record
    motion[3] = 1'b1;
    exp_at(8, F_TRIP,  8'ha, "extend_trip");
    exp_at(8, F_STATE, 8'd3, "extend_state");
    step(10);
    motion[3] = 1'b0;
    exp_at(52, F_STATE, 8'd3, "hold_last_state");
`ifndef MOTION_ALARM_LATCH_EN
    exp_at(53, F_STATE, 8'd2, "timeout_state");
    exp_at(53, F_TRIP,  8'ha, "timeout_trip");
    exp_at(53, F_BUZ,   8'd0, "timeout_buzzer");
    exp_at(53, F_ARMED, 8'd1, "timeout_armed");
    exp_at(53, F_ACT,   8'd0, "timeout_active");
    step(53);
`else
    exp_at(53, F_STATE, 8'd3, "latch_state");
    exp_at(53, F_TRIP,  8'ha, "latch_trip");
    step(70);
    exp_at(0, F_STATE, 8'd3, "latch_hold");
    ack = 1'b1;
    exp_at(1, F_STATE, 8'd2, "latch_ack_state");
    exp_at(1, F_TRIP,  8'd0, "latch_ack_trip");
    step(1);
    ack = 1'b0;
    step(2);
`endif

    // ack while sensor 0 stays debounced: back to ARMED, then straight into ALARM
    motion[0] = 1'b1;
    exp_at(8, F_STATE, 8'd3, "s0_alarm_state");
    exp_at(8, F_TRIP,  8'h1, "s0_alarm_trip");
    step(12);
    ack = 1'b1;
    exp_at(1, F_STATE, 8'd2, "ack_state");
    exp_at(1, F_TRIP,  8'd0, "ack_trip");
    exp_at(1, F_BUZ,   8'd0, "ack_buzzer");
    exp_at(1, F_ACT,   8'd0, "ack_active");
    exp_at(2, F_STATE, 8'd3, "realarm_state");
    exp_at(2, F_TRIP,  8'h1, "realarm_trip");
    exp_at(2, F_BUZ,   8'd1, "realarm_buzzer");
    step(1);
    ack = 1'b0;
    step(5);

    // Disarm together with ack: disarm wins
    arm = 1'b0;
    ack = 1'b1;
    exp_at(1, F_STATE, 8'd0, "disarm_state");
    exp_at(1, F_BUZ,   8'd0, "disarm_buzzer");
    exp_at(1, F_ARMED, 8'd0, "disarm_armed");
    exp_at(1, F_ACT,   8'd0, "disarm_active");
    step(1);
    ack = 1'b0;
    motion[0] = 1'b0;
    step(8);

    // Re-arm, trip sensor 2, then assert reset while the buzzer is high
    arm = 1'b1;
    exp_at(11, F_STATE, 8'd2, "rearm_state");
    step(12);
    motion[2] = 1'b1;
    exp_at(8, F_STATE, 8'd3, "s2_alarm_state");
    exp_at(8, F_BUZ,   8'd1, "s2_alarm_buzzer");
    step(9);
    check_eq("pre_reset_buzzer", 8'(buzzer), 8'd1);
    reset = 1'b1;
    #1;
    check_eq("async_rst_buzzer", 8'(buzzer), 8'd0);
    check_eq("async_rst_active", 8'(alarm_active), 8'd0);
    check_eq("async_rst_armed",  8'(armed), 8'd0);
    check_eq("async_rst_trip",   8'(trip_mask), 8'd0);
    check_eq("async_rst_state",  8'(state), 8'd0);
    arm    = 1'b0;
    motion = 4'b0000;
    step(2);
    reset = 1'b0;
    exp_at(1, F_STATE, 8'd0, "post_rst_state");
    exp_at(1, F_TRIP,  8'd0, "post_rst_trip");
    step(3);

    for (int i = 0; i < 100 && q_due.size() != 0; i++) @(posedge clk);
    #1;
    check_eq("sb_drain", 8'(q_due.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
